// File: rtl/instrcution.sv
// 16-bit PC incrementer: carry-lookahead adder with an optional registered status-flag bank.
// Define INSTRCUTION_FLAGS_EN to build the {neg, ovf, carry, zero} flag register; otherwise flags read 0.
module instrcution (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout,
    output logic [3:0]  flags
);

    logic [15:0] gen;
    logic [15:0] prop;
    logic [16:0] carry;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;

    assign gen      = a & b;
    assign prop     = a ^ b;
    assign carry[0] = cin;

    // Each nibble resolves its internal carries by lookahead; group carries ripple nibble to nibble.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cla
            localparam int B = 4 * gi;
            logic ci;
            assign ci = carry[B];

            assign carry[B+1] = gen[B] | (prop[B] & ci);
            assign carry[B+2] = gen[B+1] | (prop[B+1] & gen[B])
                              | (prop[B+1] & prop[B] & ci);
            assign carry[B+3] = gen[B+2] | (prop[B+2] & gen[B+1])
                              | (prop[B+2] & prop[B+1] & gen[B])
                              | (prop[B+2] & prop[B+1] & prop[B] & ci);

            assign grp_g[gi] = gen[B+3] | (prop[B+3] & gen[B+2])
                             | (prop[B+3] & prop[B+2] & gen[B+1])
                             | (prop[B+3] & prop[B+2] & prop[B+1] & gen[B]);
            assign grp_p[gi] = &prop[B+3:B];

            assign carry[B+4] = grp_g[gi] | (grp_p[gi] & ci);
        end
    endgenerate

    assign sum  = prop ^ carry[15:0];
    assign cout = carry[16];

`ifdef INSTRCUTION_FLAGS_EN
    logic [3:0] flags_reg;
    logic [3:0] flags_next;

    always_comb begin
        flags_next = {sum[15], carry[15] ^ carry[16], carry[16], (sum == 16'h0000)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_reg <= 4'b0000;
        end else begin
            flags_reg <= flags_next;
        end
    end

    assign flags = flags_reg;
`else
    logic unused_clk_reset;
    assign unused_clk_reset = &{1'b0, clk, reset};
    assign flags = 4'b0000;
`endif

endmodule

// File: tb/tb_instrcution.sv
// Randomised scoreboard bench for instrcution: the driver queues expected sum/cout/flags,
// and a negedge monitor checks combinational outputs now and flags one edge later.
module tb_instrcution;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic [3:0]  flags;

    int errors = 0;
    int checks = 0;
    bit drive_done = 1'b0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        rst;
        logic [15:0] s;
        logic        c;
        logic [3:0]  f;
    } exp_t;

    exp_t sb_q[$];

    instrcution dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .flags (flags)
    );

    always #5 clk = ~clk;

    // Reference: plain 17-bit arithmetic; signed overflow from operand/result signs.
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic mcin, input logic mrst);
        exp_t e;
        logic [16:0] full;
        logic ovf;
        full  = {1'b0, ma} + {1'b0, mb} + {16'd0, mcin};
        ovf   = (ma[15] == mb[15]) && (full[15] != ma[15]);
        e.a   = ma;
        e.b   = mb;
        e.cin = mcin;
        e.rst = mrst;
        e.s   = full[15:0];
        e.c   = full[16];
`ifdef INSTRCUTION_FLAGS_EN
        e.f   = mrst ? 4'b0000 : {full[15], ovf, full[16], (full[15:0] == 16'h0000)};
`else
        e.f   = 4'b0000;
`endif
        return e;
    endfunction

    task automatic drive(input logic [15:0] da, input logic [15:0] db,
                         input logic dcin, input logic drst);
        @(posedge clk);
        #1;
        a     = da;
        b     = db;
        cin   = dcin;
        reset = drst;
        sb_q.push_back(model(da, db, dcin, drst));
    endtask

    // Monitor: comb outputs checked against the current entry, flags against the previous one.
    initial begin : monitor
        exp_t cur;
        exp_t prev;
        bit   have_prev = 1'b0;
        int   txn = 0;
        forever begin
            @(negedge clk);
            if (have_prev) begin
                checks++;
                if (flags !== prev.f) begin
                    errors++;
                    $display("FAIL flags txn=%0d a=%h b=%h cin=%0b rst=%0b got=%b want=%b",
                             txn - 1, prev.a, prev.b, prev.cin, prev.rst, flags, prev.f);
                end
            end
            if (sb_q.size() > 0) begin
                cur = sb_q.pop_front();
                checks++;
                if (sum !== cur.s || cout !== cur.c) begin
                    errors++;
                    $display("FAIL sum_cout txn=%0d a=%h b=%h cin=%0b got=%h/%0b want=%h/%0b",
                             txn, cur.a, cur.b, cur.cin, sum, cout, cur.s, cur.c);
                end else begin
                    $display("txn %0d a=%h b=%h cin=%0b rst=%0b sum=%h cout=%0b flags=%b",
                             txn, cur.a, cur.b, cur.cin, cur.rst, sum, cout, flags);
                end
                prev      = cur;
                have_prev = 1'b1;
                txn++;
            end else begin
                have_prev = 1'b0;
            end
        end
    end

    initial begin : stimulus
        logic [15:0] pc;
        exp_t tmp;
        a = 16'h0; b = 16'h0; cin = 1'b0; reset = 1'b1;

        drive(16'h0000, 16'h0001, 1'b0, 1'b1);
        drive(16'h0000, 16'h0001, 1'b0, 1'b0);
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        drive(16'h1234, 16'h0F0F, 1'b1, 1'b0);
        drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        drive(16'h8000, 16'h8000, 1'b0, 1'b0);
        // Flags nonzero, then a single reset edge, then release.
        drive(16'h7FFF, 16'h0001, 1'b0, 1'b1);
        drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);

        // Fetch chain: PC held at FFFF in reset, then sum fed back as the next PC.
        pc = 16'hFFFF;
        drive(pc, 16'h0001, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tmp = model(pc, 16'h0001, 1'b0, 1'b0);
            pc  = tmp.s;
            drive(pc, 16'h0001, 1'b0, 1'b0);
        end

        for (int i = 0; i < 200; i++) begin
            drive(16'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
        end

        repeat (4) @(posedge clk);
        drive_done = 1'b1;
    end

    initial begin : finisher
        int budget = 0;
        while (!drive_done && budget < 5000) begin
            @(posedge clk);
            budget++;
        end
        checks++;
        if (!drive_done || sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain done=%0b pending=%0d want done=1 pending=0",
                     drive_done, sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
